// File: rtl/mips_boot_ctrl.sv
// mips_boot_ctrl
//   Boot / run / dump sequencer for the pipe_MIPS32 core. On start it optionally
//   fills the register file with Reg[k]=k, streams a program into instruction
//   memory, releases the core, waits for HALT (or a cycle limit), then streams
//   the first DUMP_REGS registers back out.
//
// Ports
//   clk1, rst                  clock (rising edge), asynchronous active-high reset
//   start                      one-cycle go pulse, honoured only in IDLE or DONE
//   load_valid/ready/data/last program word stream into the controller
//   imem_we/addr/wdata         instruction memory write port
//   rf_we/addr/wdata, rf_rdata register file init write port / dump read port
//   cpu_run, cpu_halted        core release and core HALTED flag
//   dump_valid/ready/data/idx/last  register dump stream out of the controller
//   cycle_count                cycles spent in RUN, saturating at MAX_CYCLES
//   done, timeout, load_err    sequence status flags

module mips_boot_ctrl #(
   parameter int DATA_W     = 32,
   parameter int IMEM_AW    = 10,
   parameter int RF_AW      = 5,
   parameter int DUMP_REGS  = 6,
   parameter int MAX_CYCLES = 1024,
   parameter int CNT_W      = 16,
   parameter int RF_INIT_ID = 1
) (
   input  logic               clk1,
   input  logic               rst,
   input  logic               start,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [DATA_W-1:0]  load_data,
   input  logic               load_last,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [DATA_W-1:0]  imem_wdata,
   output logic               rf_we,
   output logic [RF_AW-1:0]   rf_addr,
   output logic [DATA_W-1:0]  rf_wdata,
   input  logic [DATA_W-1:0]  rf_rdata,
   output logic               cpu_run,
   input  logic               cpu_halted,
   output logic               dump_valid,
   input  logic               dump_ready,
   output logic [DATA_W-1:0]  dump_data,
   output logic [RF_AW-1:0]   dump_idx,
   output logic               dump_last,
   output logic [CNT_W-1:0]   cycle_count,
   output logic               done,
   output logic               timeout,
   output logic               load_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT_RF, S_LOAD, S_RUN, S_DUMP, S_DONE, S_ERR
   } state_t;

   localparam logic [RF_AW-1:0]   RF_LAST   = '1;
   localparam logic [IMEM_AW-1:0] IMEM_LAST = '1;
   localparam logic [RF_AW-1:0]   DUMP_LAST = RF_AW'(DUMP_REGS - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(MAX_CYCLES);

   state_t             state, state_nxt;
   logic [RF_AW-1:0]   rf_k;     // register being initialised
   logic [IMEM_AW-1:0] wcnt;     // next program word address
   logic [RF_AW-1:0]   idx;      // register being dumped
   logic               accept;
   logic               beat;
   logic               dump_hs;

   assign accept  = start && (state == S_IDLE || state == S_DONE);
   assign beat    = (state == S_LOAD) && load_valid;
   assign dump_hs = (state == S_DUMP) && dump_valid && dump_ready;

   // Next state and the purely state-decoded outputs. cpu_run is decoded from
   // the state so an asynchronous reset removes it in the same instant.
   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = '0;
      imem_wdata = '0;
      rf_we      = 1'b0;
      rf_addr    = '0;
      rf_wdata   = '0;
      cpu_run    = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) state_nxt = (RF_INIT_ID != 0) ? S_INIT_RF : S_LOAD;
         end
         S_INIT_RF: begin
            rf_we    = 1'b1;
            rf_addr  = rf_k;
            rf_wdata = DATA_W'(rf_k);
            if (rf_k == RF_LAST) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            load_ready = 1'b1;
            imem_we    = load_valid;
            imem_addr  = wcnt;
            imem_wdata = load_data;
            if (beat) begin
               if (load_last)              state_nxt = S_RUN;
               else if (wcnt == IMEM_LAST) state_nxt = S_ERR;
            end
         end
         S_RUN: begin
            cpu_run = 1'b1;
            // HALT is tested first so a halt on the limit cycle is not a timeout.
            if (cpu_halted || cycle_count >= CNT_MAX) state_nxt = S_DUMP;
         end
         S_DUMP: begin
            rf_addr = idx;
            if (dump_hs && dump_last) state_nxt = S_DONE;
         end
         S_ERR:   state_nxt = S_ERR;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register, counters and registered outputs.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         rf_k        <= '0;
         wcnt        <= '0;
         idx         <= '0;
         cycle_count <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         load_err    <= 1'b0;
         dump_valid  <= 1'b0;
         dump_data   <= '0;
         dump_idx    <= '0;
         dump_last   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  done        <= 1'b0;
                  timeout     <= 1'b0;
                  load_err    <= 1'b0;
                  cycle_count <= '0;
                  rf_k        <= '0;
                  wcnt        <= '0;
                  idx         <= '0;
               end
            end
            S_INIT_RF: rf_k <= rf_k + RF_AW'(1);
            S_LOAD: begin
               if (beat) begin
                  wcnt <= wcnt + IMEM_AW'(1);
                  // The first RUN cycle already reports one cycle.
                  if (load_last)              cycle_count <= CNT_W'(1);
                  else if (wcnt == IMEM_LAST) load_err    <= 1'b1;
               end
            end
            S_RUN: begin
               if (cpu_halted)                timeout     <= 1'b0;
               else if (cycle_count >= CNT_MAX) timeout   <= 1'b1;
               else                           cycle_count <= cycle_count + CNT_W'(1);
            end
            S_DUMP: begin
               // A word is captured from the combinational read one cycle after
               // rf_addr moves, then held until the consumer takes it.
               if (!dump_valid) begin
                  dump_valid <= 1'b1;
                  dump_data  <= rf_rdata;
                  dump_idx   <= idx;
                  dump_last  <= (idx == DUMP_LAST);
               end else if (dump_ready) begin
                  dump_valid <= 1'b0;
                  dump_data  <= '0;
                  dump_idx   <= '0;
                  dump_last  <= 1'b0;
                  if (dump_last) done <= 1'b1;
                  else           idx  <= idx + RF_AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// tb_mips_boot_ctrl
//   Drives mips_boot_ctrl with a small behavioural core (ADD/ADDI/OR/HLT) and
//   memories, and checks each sequence against a reference that derives the
//   dumped registers, cycle count and timeout directly from the program words.

module tb_mips_boot_ctrl;

   localparam int DW   = 32;
   localparam int IAW  = 6;
   localparam int RAW  = 5;
   localparam int NDMP = 6;
   localparam int MAXC = 50;
   localparam int CW   = 16;
   localparam logic [31:0] HLT = 32'hfc000000;

   logic           clk1 = 1'b0, rst = 1'b1, start = 1'b0;
   logic           load_valid = 1'b0, load_last = 1'b0, dump_ready = 1'b0;
   logic [DW-1:0]  load_data = '0;
   logic           load_ready, imem_we, rf_we, cpu_run, cpu_halted;
   logic [IAW-1:0] imem_addr;
   logic [DW-1:0]  imem_wdata, rf_wdata, rf_rdata, dump_data;
   logic [RAW-1:0] rf_addr, dump_idx;
   logic           dump_valid, dump_last, done, timeout, load_err;
   logic [CW-1:0]  cycle_count;
   logic [136:0]   outs;

   mips_boot_ctrl #(
      .DATA_W(DW), .IMEM_AW(IAW), .RF_AW(RAW), .DUMP_REGS(NDMP),
      .MAX_CYCLES(MAXC), .CNT_W(CW), .RF_INIT_ID(1)
   ) dut (
      .clk1(clk1), .rst(rst), .start(start),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .load_last(load_last), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .rf_we(rf_we), .rf_addr(rf_addr),
      .rf_wdata(rf_wdata), .rf_rdata(rf_rdata), .cpu_run(cpu_run),
      .cpu_halted(cpu_halted), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_data(dump_data), .dump_idx(dump_idx), .dump_last(dump_last),
      .cycle_count(cycle_count), .done(done), .timeout(timeout), .load_err(load_err)
   );

   always #5 clk1 = ~clk1;

   assign outs = {load_ready, imem_we, imem_addr, imem_wdata, rf_we, rf_addr, rf_wdata,
                  cpu_run, dump_valid, dump_data, dump_idx, dump_last, cycle_count,
                  done, timeout, load_err};

   // Memories and a one-instruction-per-cycle core.
   logic [31:0] imem [0:(1<<IAW)-1];
   logic [31:0] rf_mem [0:(1<<RAW)-1];
   int          pc = 0;
   logic        core_halt = 1'b0;
   int          imem_wr_tot = 0, rf_wr_tot = 0;

   assign rf_rdata   = rf_mem[rf_addr];
   assign cpu_halted = core_halt;

   always @(posedge clk1) begin : core
      logic [31:0] ci;
      if (rf_we) begin
         rf_mem[rf_addr] <= rf_wdata;
         rf_wr_tot <= rf_wr_tot + 1;
      end
      if (imem_we) begin
         imem[imem_addr] <= imem_wdata;
         imem_wr_tot <= imem_wr_tot + 1;
      end
      if (!cpu_run) begin
         pc        <= 0;
         core_halt <= 1'b0;
      end else if (!core_halt) begin
         ci = imem[pc];
         case (ci[31:26])
            6'h00: rf_mem[ci[15:11]] <= rf_mem[ci[25:21]] + rf_mem[ci[20:16]];
            6'h0a: rf_mem[ci[20:16]] <= rf_mem[ci[25:21]] + {{16{ci[15]}}, ci[15:0]};
            6'h03: rf_mem[ci[15:11]] <= rf_mem[ci[25:21]] | rf_mem[ci[20:16]];
            6'h3f: core_halt <= 1'b1;
            default: ;
         endcase
         pc <= pc + 1;
      end
   end

   int n_chk = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   logic [31:0] prog [$];
   logic [31:0] got_d [0:15];
   int          got_i [0:15];
   logic        got_l [0:15];

   function automatic logic [31:0] rand_instr();
      logic [4:0] rs, rt, rd;
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(1, 7));
      rd = 5'($urandom_range(1, 7));
      if ($urandom % 2 == 0) return {6'h0a, rs, rt, 16'($urandom)};
      return {6'h00, rs, rt, rd, 11'h0};
   endfunction

   // One complete start..done sequence with random load gaps, random dump
   // backpressure and stray start pulses while the core runs.
   task automatic run_seq(input string nm);
      int          L, i, cyc, nb, ecnt, nerr, imem0, rf0;
      bit          eto, stalled;
      logic [31:0] er [0:31];
      logic [31:0] w, sdata;
      logic [4:0]  sidx;

      L    = prog.size();
      ecnt = MAXC;
      eto  = 1'b1;
      for (int k = 0; k < 32; k++) er[k] = k;
      for (int j = 0; j < L && j < MAXC; j++) begin
         w = prog[j];
         if (w == HLT) begin
            if (j + 2 <= MAXC) begin
               ecnt = j + 2;
               eto  = 1'b0;
            end
            break;
         end
         if (w[31:26] == 6'h0a)      er[w[20:16]] = er[w[25:21]] + {{16{w[15]}}, w[15:0]};
         else if (w[31:26] == 6'h00) er[w[15:11]] = er[w[25:21]] + er[w[20:16]];
         else if (w[31:26] == 6'h03) er[w[15:11]] = er[w[25:21]] | er[w[20:16]];
      end

      imem0 = imem_wr_tot;
      rf0   = rf_wr_tot;
      @(negedge clk1) start = 1'b1;
      @(negedge clk1) start = 1'b0;
      i = 0; nb = 0; cyc = 0; stalled = 1'b0;
      while (!done && cyc < 3000) begin
         if (stalled) begin
            chk({nm, ".stall_vld"}, dump_valid, 1'b1);
            chk({nm, ".stall_data"}, dump_data, sdata);
            chk({nm, ".stall_idx"}, dump_idx, sidx);
         end
         dump_ready = 1'($urandom % 2);
         stalled    = dump_valid && !dump_ready;
         sdata      = dump_data;
         sidx       = dump_idx;
         if (dump_valid && dump_ready) begin
            if (nb < 16) begin
               got_d[nb] = dump_data;
               got_i[nb] = int'(dump_idx);
               got_l[nb] = dump_last;
            end
            nb++;
         end
         start = cpu_run && ($urandom % 8 == 0);
         if (i < L) begin
            load_valid = ($urandom % 4 != 0);
            load_data  = prog[i];
            load_last  = (i == L - 1);
            if (load_valid && load_ready) i++;
         end else begin
            load_valid = 1'b0;
            load_last  = 1'b0;
         end
         @(negedge clk1);
         cyc++;
      end
      start = 1'b0; load_valid = 1'b0; load_last = 1'b0; dump_ready = 1'b0;

      chk({nm, ".done"}, done, 1'b1);
      chk({nm, ".timeout"}, timeout, eto);
      chk({nm, ".cycles"}, cycle_count, ecnt);
      chk({nm, ".cpu_run"}, cpu_run, 1'b0);
      chk({nm, ".beats"}, nb, NDMP);
      for (int b = 0; b < NDMP && b < nb; b++) begin
         chk($sformatf("%s.dump_data%0d", nm, b), got_d[b], er[b]);
         chk($sformatf("%s.dump_idx%0d", nm, b), got_i[b], b);
         chk($sformatf("%s.dump_last%0d", nm, b), got_l[b], b == NDMP - 1);
      end
      chk({nm, ".imem_writes"}, imem_wr_tot - imem0, L);
      nerr = 0;
      for (int j = 0; j < L; j++) if (imem[j] !== prog[j]) nerr++;
      chk({nm, ".imem_content"}, nerr, 0);
      chk({nm, ".rf_init_writes"}, rf_wr_tot - rf0, 32);
      nerr = 0;
      for (int k = 8; k < 32; k++) if (k != 15 && rf_mem[k] !== 32'(k)) nerr++;
      chk({nm, ".rf_untouched"}, nerr, 0);
   endtask

   initial begin
      int          cyc, imem0;
      int          spec_vals [0:5];
      logic [31:0] ovf [0:64];
      spec_vals = '{0, 10, 20, 25, 30, 55};

      // reset state
      #1;
      chk("rst.outputs", 64'(|outs), 0);
      repeat (2) @(negedge clk1);
      rst = 1'b0;

      // reset in the middle of LOAD
      @(negedge clk1) start = 1'b1;
      @(negedge clk1) start = 1'b0;
      cyc = 0;
      while (!load_ready && cyc < 100) begin
         @(negedge clk1);
         cyc++;
      end
      chk("midload.reach_load", load_ready, 1'b1);
      load_valid = 1'b1; load_data = 32'h2801000a;
      @(negedge clk1) load_data = 32'h28020014;
      @(negedge clk1);
      rst = 1'b1;
      #1;
      chk("midload.outputs", 64'(|outs), 0);
      @(negedge clk1);
      rst = 1'b0; load_valid = 1'b0; load_data = '0;

      // reference program
      prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
               32'h00222000, 32'h0ce77800, 32'h00832800, HLT};
      run_seq("prog");
      for (int b = 0; b < NDMP; b++)
         chk($sformatf("prog.known_r%0d", b), got_d[b], spec_vals[b]);

      // never halts
      prog.delete();
      for (int j = 0; j < 55; j++) prog.push_back(rand_instr());
      run_seq("nohalt");

      // halt exactly on the limit cycle, and one cycle too late
      prog.delete();
      for (int j = 0; j < 48; j++) prog.push_back(rand_instr());
      prog.push_back(HLT);
      run_seq("halt_at_limit");
      prog.delete();
      for (int j = 0; j < 49; j++) prog.push_back(rand_instr());
      prog.push_back(HLT);
      run_seq("halt_past_limit");

      // random programs, back to back from DONE
      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(2, 58);
         prog.delete();
         for (int j = 0; j < n; j++) prog.push_back(rand_instr());
         prog.push_back(HLT);
         run_seq($sformatf("rand%0d", r));
      end

      // IMEM overflow
      for (int j = 0; j < 65; j++) ovf[j] = $urandom;
      imem0 = imem_wr_tot;
      @(negedge clk1) start = 1'b1;
      @(negedge clk1) start = 1'b0;
      begin
         int i;
         i = 0; cyc = 0;
         while (!load_err && cyc < 500) begin
            load_valid = 1'b1;
            load_last  = 1'b0;
            load_data  = ovf[i];
            if (load_ready) i++;
            @(negedge clk1);
            cyc++;
         end
         chk("ovf.accepted", i, 64);
      end
      chk("ovf.load_err", load_err, 1'b1);
      chk("ovf.ready_after", load_ready, 1'b0);
      repeat (3) @(negedge clk1);
      chk("ovf.writes", imem_wr_tot - imem0, 64);
      chk("ovf.word0", imem[0], ovf[0]);
      chk("ovf.word63", imem[63], ovf[63]);
      chk("ovf.idle_outputs", 64'(|outs[136:1]), 0);
      load_valid = 1'b0;
      start = 1'b1;
      @(negedge clk1) start = 1'b0;
      repeat (2) @(negedge clk1);
      chk("ovf.start_ignored", {load_err, load_ready, rf_we}, 3'b100);
      rst = 1'b1;
      #1;
      chk("ovf.rst_clears", 64'(|outs), 0);
      @(negedge clk1) rst = 1'b0;

      // recovery after reset
      prog.delete();
      for (int j = 0; j < 10; j++) prog.push_back(rand_instr());
      prog.push_back(HLT);
      run_seq("recover");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
